// File: rtl/tone_pkg.sv
// Shared constants and the note table for the tone keyboard.
// Terms are half-period counter terminal values at a given clock.
package tone_pkg;

    localparam int F_CLK    = 12000000;
    localparam int MAX_KEYS = 8;

    // Note frequencies in millihertz, C4 up to C5.
    function automatic longint note_mhz(input int i);
        case (i)
            0:       return 64'd261626;
            1:       return 64'd293665;
            2:       return 64'd329628;
            3:       return 64'd349228;
            4:       return 64'd391995;
            5:       return 64'd440000;
            6:       return 64'd493883;
            default: return 64'd523251;
        endcase
    endfunction

    // round(f_clk / (2*f)) - 1, done in integer millihertz.
    function automatic int note_term(input longint f_clk, input int i);
        longint f;
        f = note_mhz(i);
        return int'((f_clk * 1000 + f) / (2 * f) - 1);
    endfunction

    localparam int NOTE_T [MAX_KEYS] = '{
        note_term(F_CLK, 0), note_term(F_CLK, 1),
        note_term(F_CLK, 2), note_term(F_CLK, 3),
        note_term(F_CLK, 4), note_term(F_CLK, 5),
        note_term(F_CLK, 6), note_term(F_CLK, 7)
    };

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: tracks the sounding note and restarts
// the phase whenever key, octave or validity changes.
module tone_divider
    import tone_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p_valid,
    input  logic [2:0]       p_idx,
    input  logic [1:0]       p_oct,
    input  logic [CNT_W-1:0] p_term,
    output logic             cur_valid,
    output logic [2:0]       cur_idx,
    output logic             sq
);

    logic [1:0]       cur_oct;
    logic [CNT_W-1:0] cnt;
    logic             change;

    assign change = (p_valid != cur_valid) ||
                    (p_idx   != cur_idx)   ||
                    (p_oct   != cur_oct);

    // Latch new note with phase restart, else count half-periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid <= 1'b0;
            cur_idx   <= '0;
            cur_oct   <= '0;
            cnt       <= '0;
            sq        <= 1'b0;
        end else if (change) begin
            cur_valid <= p_valid;
            cur_idx   <= p_idx;
            cur_oct   <= p_oct;
            cnt       <= '0;
            sq        <= p_valid;
        end else if (cur_valid) begin
            if (cnt == p_term) begin
                cnt <= '0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
            sq  <= 1'b0;
        end
    end

endmodule

// File: rtl/tone_keyboard.sv
// Multi-key square-wave tone player: sync, priority pick, table
// lookup with octave shift, then the divider.
module tone_keyboard
    import tone_pkg::*;
#(
    parameter int NUM_KEYS = 8,
    parameter int CNT_W    = 16,
    parameter int F_CLK    = 12000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] btn,
    input  logic [1:0]          oct,
    output logic [NUM_KEYS-1:0] key_leds,
    output logic                note_valid,
    output logic [2:0]          note_idx,
    output logic                pwmout
);

    localparam int TBL [MAX_KEYS] = '{
        note_term(F_CLK, 0), note_term(F_CLK, 1),
        note_term(F_CLK, 2), note_term(F_CLK, 3),
        note_term(F_CLK, 4), note_term(F_CLK, 5),
        note_term(F_CLK, 6), note_term(F_CLK, 7)
    };

    logic [NUM_KEYS-1:0] k_s1, k_s2;
    logic [1:0]          o_s1, o_s2;
    logic                enc_valid;
    logic [2:0]          enc_idx;
    logic [CNT_W-1:0]    base;
    logic [CNT_W:0]      half;
    logic [CNT_W-1:0]    term;
    logic                p_valid;
    logic [2:0]          p_idx;
    logic [1:0]          p_oct;
    logic [CNT_W-1:0]    p_term;

    // Two-flop synchroniser; buttons inverted to active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_s1 <= '0;
            k_s2 <= '0;
            o_s1 <= '0;
            o_s2 <= '0;
        end else begin
            k_s1 <= ~btn;
            k_s2 <= k_s1;
            o_s1 <= oct;
            o_s2 <= o_s1;
        end
    end

    assign key_leds = k_s2;

    // Lowest pressed index wins.
    always_comb begin
        enc_valid = |k_s2;
        enc_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (k_s2[i]) enc_idx = 3'(i);
        end
    end

    // Octave shift divides the half-period, rounding down.
    always_comb begin
        base = CNT_W'(TBL[enc_idx]);
        half = ({1'b0, base} + 1'b1) >> o_s2;
        term = half[CNT_W-1:0] - 1'b1;
    end

    // Registered note selection feeding the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_idx   <= '0;
            p_oct   <= '0;
            p_term  <= '0;
        end else begin
            p_valid <= enc_valid;
            p_idx   <= enc_idx;
            p_oct   <= o_s2;
            p_term  <= term;
        end
    end

    tone_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_valid  (p_valid),
        .p_idx    (p_idx),
        .p_oct    (p_oct),
        .p_term   (p_term),
        .cur_valid(note_valid),
        .cur_idx  (note_idx),
        .sq       (pwmout)
    );

endmodule
